// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded control and operands for EX, with stall, bubble and valid tag.
// Define ID_EX_BUBBLE_COUNT_EN to add the saturating bubble_count output.
module id_ex_pipe_reg #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic            id_MemRead,
    input  logic            id_MemtoReg,
    input  logic            id_MemWrite,
    input  logic            id_RegWrite,
    input  logic            id_Branch,
    input  logic            id_ALUSrc,
    input  logic [1:0]      id_ALUop,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [3:0]      id_funct,
    output logic            ex_valid,
    output logic            ex_MemRead,
    output logic            ex_MemtoReg,
    output logic            ex_MemWrite,
    output logic            ex_RegWrite,
    output logic            ex_Branch,
    output logic            ex_ALUSrc,
    output logic [1:0]      ex_ALUop,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic [3:0]      ex_funct,
    output logic            ex_load_hazard
`ifdef ID_EX_BUBBLE_COUNT_EN
    ,
    output logic [31:0]     bubble_count
`endif
);

    typedef struct packed {
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [3:0]      funct;
    } data_t;

    ctrl_t ctrl_d, ctrl_q;
    data_t data_d, data_q;
    logic  valid_q;

    // NOTE: every field gets a default first so no path through the block can infer a latch.
    always_comb begin
        ctrl_d            = '0;
        ctrl_d.mem_read   = id_MemRead  & id_valid;
        // MemtoReg is a don't-care from the decoder unless the instruction writes a register.
        ctrl_d.mem_to_reg = id_MemtoReg & id_RegWrite & id_valid;
        ctrl_d.mem_write  = id_MemWrite & id_valid;
        ctrl_d.reg_write  = id_RegWrite & id_valid;
        ctrl_d.branch     = id_Branch   & id_valid;
        ctrl_d.alu_src    = id_ALUSrc   & id_valid;
        ctrl_d.alu_op     = id_ALUop    & {2{id_valid}};

        data_d          = '0;
        data_d.pc       = id_pc;
        data_d.rs1_data = id_rs1_data;
        data_d.rs2_data = id_rs2_data;
        data_d.imm      = id_imm;
        data_d.rs1      = id_rs1;
        data_d.rs2      = id_rs2;
        data_d.rd       = id_rd;
        data_d.funct    = id_funct;
    end

    // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (!stall) begin
            valid_q <= id_valid;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_MemRead  = ctrl_q.mem_read;
    assign ex_MemtoReg = ctrl_q.mem_to_reg;
    assign ex_MemWrite = ctrl_q.mem_write;
    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_Branch   = ctrl_q.branch;
    assign ex_ALUSrc   = ctrl_q.alu_src;
    assign ex_ALUop    = ctrl_q.alu_op;
    assign ex_pc       = data_q.pc;
    assign ex_rs1_data = data_q.rs1_data;
    assign ex_rs2_data = data_q.rs2_data;
    assign ex_imm      = data_q.imm;
    assign ex_rs1      = data_q.rs1;
    assign ex_rs2      = data_q.rs2;
    assign ex_rd       = data_q.rd;
    assign ex_funct    = data_q.funct;

    assign ex_load_hazard = valid_q & ctrl_q.mem_read & (data_q.rd != '0);

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] bubble_q;
    logic        load_bubble;

    assign load_bubble = flush | (~stall & ~id_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_q <= '0;
        end else if (load_bubble && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_q <= bubble_q + 32'd1;
        end
    end

    assign bubble_count = bubble_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a behavioural model pushes the expected EX state each edge,
// which is popped and compared one time unit after the edge.
module tb_id_ex_pipe_reg;

    localparam int XLEN = 64;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            reset, stall, flush, id_valid;
    logic            id_MemRead, id_MemtoReg, id_MemWrite, id_RegWrite, id_Branch, id_ALUSrc;
    logic [1:0]      id_ALUop;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic [3:0]      id_funct;
    logic            ex_valid, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite, ex_Branch, ex_ALUSrc;
    logic [1:0]      ex_ALUop;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0]      ex_funct;
    logic            ex_load_hazard;
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0]     bubble_count;
`endif

    id_ex_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite),
        .id_RegWrite(id_RegWrite), .id_Branch(id_Branch), .id_ALUSrc(id_ALUSrc), .id_ALUop(id_ALUop),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
        .ex_MemWrite(ex_MemWrite), .ex_RegWrite(ex_RegWrite), .ex_Branch(ex_Branch),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUop(ex_ALUop), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_load_hazard(ex_load_hazard)
`ifdef ID_EX_BUBBLE_COUNT_EN
        , .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;

    // Control packed as {MemRead, MemtoReg, MemWrite, RegWrite, Branch, ALUSrc, ALUop[1:0]}.
    typedef struct {
        logic            valid;
        logic [7:0]      ctrl;
        logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
        logic [RA_W-1:0] rs1, rs2, rd;
        logic [3:0]      funct;
        logic            hazard;
        logic [31:0]     bcnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t model;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t predict(input exp_t cur);
        exp_t n;
        n = cur;
        if (reset) begin
            n = '{default: '0};
        end else if (flush) begin
            n      = '{default: '0};
            n.bcnt = (cur.bcnt == 32'hFFFF_FFFF) ? cur.bcnt : cur.bcnt + 32'd1;
        end else if (!stall) begin
            n.valid = id_valid;
            if (id_valid)
                n.ctrl = {id_MemRead, id_MemtoReg & id_RegWrite, id_MemWrite, id_RegWrite,
                          id_Branch, id_ALUSrc, id_ALUop};
            else
                n.ctrl = 8'h00;
            n.pc = id_pc; n.rs1_data = id_rs1_data; n.rs2_data = id_rs2_data; n.imm = id_imm;
            n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.funct = id_funct;
            if (!id_valid)
                n.bcnt = (cur.bcnt == 32'hFFFF_FFFF) ? cur.bcnt : cur.bcnt + 32'd1;
        end
        n.hazard = 1'b0;
        if (n.valid && n.ctrl[7] && n.rd != 0)
            n.hazard = 1'b1;
        return n;
    endfunction

    // One clock: push the prediction, let the edge pass, pop and compare every EX output.
    task automatic cycle();
        exp_t e;
        exp_q.push_back(predict(model));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        model = e;
        check("valid",    64'(ex_valid), 64'(e.valid));
        check("ctrl",     64'({ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite, ex_Branch,
                               ex_ALUSrc, ex_ALUop}), 64'(e.ctrl));
        check("pc",       ex_pc, e.pc);
        check("rs1_data", ex_rs1_data, e.rs1_data);
        check("rs2_data", ex_rs2_data, e.rs2_data);
        check("imm",      ex_imm, e.imm);
        check("addrs",    64'({ex_rs1, ex_rs2, ex_rd}), 64'({e.rs1, e.rs2, e.rd}));
        check("funct",    64'(ex_funct), 64'(e.funct));
        check("hazard",   64'(ex_load_hazard), 64'(e.hazard));
`ifdef ID_EX_BUBBLE_COUNT_EN
        check("bubble_count", 64'(bubble_count), 64'(e.bcnt));
`endif
    endtask

    task automatic drive_instr(input logic v, input logic [7:0] c, input logic [RA_W-1:0] rd);
        id_valid = v;
        {id_MemRead, id_MemtoReg, id_MemWrite, id_RegWrite, id_Branch, id_ALUSrc, id_ALUop} = c;
        id_rd       = rd;
        id_pc       = {$urandom, $urandom};
        id_rs1_data = {$urandom, $urandom};
        id_rs2_data = {$urandom, $urandom};
        id_imm      = {$urandom, $urandom};
        id_rs1      = RA_W'($urandom);
        id_rs2      = RA_W'($urandom);
        id_funct    = 4'($urandom);
    endtask

    initial begin
        model = '{default: '0};
        stall = 1'b0; flush = 1'b0;
        reset = 1'b1;
        drive_instr(1'b1, 8'hFF, 5'd31);
        #1;
        cycle();
        cycle();
        check("reset_valid", 64'(ex_valid), 64'd0);
        check("reset_pc", ex_pc, 64'd0);
        reset = 1'b0;

        // R-format add
        drive_instr(1'b1, 8'b0001_0010, 5'd5);
        id_rs1_data = 64'h10;
        cycle();
        check("rfmt_regwrite", 64'(ex_RegWrite), 64'd1);
        check("rfmt_aluop", 64'(ex_ALUop), 64'd2);
        check("rfmt_rs1_data", ex_rs1_data, 64'h10);

        // ld x7, then two stall cycles with changing ID contents
        drive_instr(1'b1, 8'b1101_0100, 5'd7);
        cycle();
        check("ld_hazard_0", 64'(ex_load_hazard), 64'd1);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_instr(1'b1, 8'b0001_0010, 5'd9);
            cycle();
            check("stall_rd", 64'(ex_rd), 64'd7);
            check("stall_hazard", 64'(ex_load_hazard), 64'd1);
        end
        stall = 1'b0;
        cycle();
        check("unstall_rd", 64'(ex_rd), 64'd9);

        // ld x0 never raises the hazard
        drive_instr(1'b1, 8'b1101_0100, 5'd0);
        cycle();
        check("ld_x0_memread", 64'(ex_MemRead), 64'd1);
        check("ld_x0_hazard", 64'(ex_load_hazard), 64'd0);

        // beq in EX, then flush and stall together
        drive_instr(1'b1, 8'b0000_1001, 5'd3);
        cycle();
        check("beq_branch", 64'(ex_Branch), 64'd1);
        flush = 1'b1; stall = 1'b1;
        drive_instr(1'b1, 8'hFF, 5'd12);
        cycle();
        check("flush_valid", 64'(ex_valid), 64'd0);
        check("flush_branch", 64'(ex_Branch), 64'd0);
        flush = 1'b0; stall = 1'b0;

        // sd with a garbage MemtoReg from the decoder
        drive_instr(1'b1, 8'b0110_0100, 5'd4);
        cycle();
        check("store_memtoreg", 64'(ex_MemtoReg), 64'd0);
        check("store_memwrite", 64'(ex_MemWrite), 64'd1);

        // Invalid ID slot with RegWrite set
        drive_instr(1'b0, 8'b0001_0010, 5'd6);
        cycle();
        check("invalid_regwrite", 64'(ex_RegWrite), 64'd0);

        // Stall while a bubble sits in EX
        stall = 1'b1;
        drive_instr(1'b1, 8'b1101_0100, 5'd8);
        cycle();
        check("stall_bubble_valid", 64'(ex_valid), 64'd0);
        stall = 1'b0;

        // Random mix of stall/flush/valid/reset
        for (int i = 0; i < 60; i++) begin
            drive_instr(1'($urandom_range(0, 3) != 0), 8'($urandom), 5'($urandom));
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 19) == 0);
            cycle();
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0;

`ifdef ID_EX_BUBBLE_COUNT_EN
        // Preset the counter just below saturation
        #2;
        force dut.bubble_q = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_q;
        model.bcnt = 32'hFFFF_FFFE;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("sat_count", 64'(bubble_count), 64'hFFFF_FFFF);
        end
        flush = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core. It sits directly downstream of the decode-stage control unit.
- Captures the decoded control bits (MemRead, MemtoReg, MemWrite, RegWrite, Branch, ALUSrc, ALUop) and the ID-stage operands each cycle, and presents them to EX.
- Supports hold (stall), bubble insertion (flush/squash), and a valid tag.
- Exposes registered load/rd information to the hazard detection unit.

Parameters:
- XLEN, 64, datapath width of PC, register operands and immediate.
- RA_W, 5, register-address width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold all registered contents this cycle.
- flush  input  1  load a bubble this cycle (branch taken / squash).
- id_valid  input  1  ID stage holds a real instruction.
- id_MemRead, id_MemtoReg, id_MemWrite, id_RegWrite, id_Branch, id_ALUSrc  input  1 each  control bits from the control unit.
- id_ALUop  input  2  ALU operation class.
- id_pc  input  XLEN  PC of ID instruction.
- id_rs1_data, id_rs2_data  input  XLEN  register-file read data.
- id_imm  input  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  input  RA_W  register addresses.
- id_funct  input  4  {instr[30], funct3}.
- ex_valid  output  1  EX holds a real instruction.
- ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite, ex_Branch, ex_ALUSrc  output  1 each  registered control.
- ex_ALUop  output  2  registered ALU op class.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN  registered operands.
- ex_rs1, ex_rs2, ex_rd  output  RA_W  registered addresses.
- ex_funct  output  4  registered funct.
- ex_load_hazard  output  1  ex_valid & ex_MemRead & (ex_rd != 0); combinational from registers.

Behaviour:
- Reset:
  - All outputs are 0 one cycle after reset is sampled high.
  - Reset has the highest priority over flush, stall and load.
- Update priority each rising edge: reset > flush > stall > load.
- Flush (bubble):
  - ex_valid and all eight control bits (the six single bits plus the 2-bit ex_ALUop) become 0.
  - Data and address fields become 0.
  - flush=1 together with stall=1 still loads the bubble; flush wins.
- Stall: every register holds its current value, including ex_valid.
- Load (neither flush nor stall):
  - All data, address and funct fields capture the id_* values.
  - ex_valid <= id_valid.
  - Control bits capture id_* ANDed with id_valid, so id_valid=0 always yields all-zero control.
- X handling:
  - An X on id_MemtoReg is forced to 0 in the stored value whenever id_RegWrite=0 or id_valid=0.
  - ex_MemtoReg is therefore never X after a store or branch.
- Latency: exactly 1 cycle from id_* to ex_*; no combinational path from id_* to ex_*.
- ex_load_hazard:
  - Depends only on registered state.
  - It is 0 for rd=x0 and for bubbles.
  - It remains asserted through consecutive stall cycles.
- No internal state machine beyond the pipeline registers and the optional counter.
- Stall with ex_valid=0 holds the bubble; no spurious valid appears.

Optional Feature:
- Macro: ID_EX_BUBBLE_COUNT_EN.
- With the macro defined:
  - Extra output port bubble_count (32 bits).
  - It increments on each rising edge that loads a bubble: flush=1, or a load with id_valid=0.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared to 0 by reset.
  - Stall cycles do not increment it.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset for 2 cycles with id_* driven nonzero → all ex_* = 0, ex_valid=0, bubble_count=0.
- Load R-format (id_valid=1, RegWrite=1, ALUop=2'b10, id_rd=5, id_rs1_data=64'h10) → next cycle ex_RegWrite=1, ex_ALUop=2'b10, ex_rd=5, ex_rs1_data=64'h10, ex_valid=1.
- Load ld (MemRead=1, MemtoReg=1, rd=7), then stall=1 for 2 cycles while id_* changes → ex_rd stays 7 and ex_load_hazard=1 for all 3 cycles; then stall=0 → new id_* captured.
- ld with rd=0 → ex_load_hazard=0 while ex_MemRead=1.
- flush=1 and stall=1 together while EX holds a valid beq → next cycle ex_valid=0, ex_Branch=0, all control 0; bubble_count +1.
- Store with id_MemtoReg=X and id_MemWrite=1 → ex_MemtoReg=0, ex_MemWrite=1.
- id_valid=0 with id_RegWrite=1 → ex_RegWrite=0; bubble_count +1.
- Counter preset near max via 2^32 bubbles (or forced) → holds at FFFF_FFFF.
